// File: rtl/dual_issue_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// issue_pkg
// Shared types and constants for the dual-issue front end.
//   issue_slot_t : one queued instruction (83 bits) carrying its PC, raw
//                  encoding, register specifiers and class flags.
//   REG_X0       : architectural zero register; writes to it never create
//                  a dependency.
//   ISSUE_SLOT_W : packed width of issue_slot_t.
// ---------------------------------------------------------------------------
package issue_pkg;

    localparam logic [4:0] REG_X0       = 5'd0;
    localparam int         ISSUE_SLOT_W = 83;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jump;
    } issue_slot_t;

endpackage

// File: rtl/dual_issue_sequencer_pair.sv
// ---------------------------------------------------------------------------
// dual_issue_unit
// Pairing rules for the two oldest queued instructions.
//   valid0 / valid1 : slot0 / slot1 hold real instructions
//   slot0 / slot1   : older / younger instruction
//   issue0          : slot0 may issue
//   issue1          : slot1 may issue alongside slot0 in the same cycle
// ---------------------------------------------------------------------------
module dual_issue_unit
    import issue_pkg::*;
(
    input  logic        valid0,
    input  logic        valid1,
    input  issue_slot_t slot0,
    input  issue_slot_t slot1,
    output logic        issue0,
    output logic        issue1
);

    logic raw_hazard;
    logic waw_hazard;
    logic has_control;
    logic both_mem;

    // A write to x0 is discarded, so it can never feed or clobber the
    // younger instruction.
    assign raw_hazard  = (slot0.rd != REG_X0) &&
                         ((slot0.rd == slot1.rs1) || (slot0.rd == slot1.rs2));
    assign waw_hazard  = (slot0.rd != REG_X0) && (slot0.rd == slot1.rd);

    // Control transfers always issue alone; only one lane has a memory port.
    assign has_control = slot0.is_branch || slot0.is_jump ||
                         slot1.is_branch || slot1.is_jump;
    assign both_mem    = (slot0.is_load || slot0.is_store) &&
                         (slot1.is_load || slot1.is_store);

    assign issue0 = valid0;
    assign issue1 = valid0 && valid1 &&
                    !(raw_hazard || waw_hazard || has_control || both_mem);

endmodule

// File: rtl/dual_issue_sequencer.sv
// ---------------------------------------------------------------------------
// dual_issue_sequencer
// Circular instruction buffer between fetch and the two execute lanes.
// Accepts one or two instructions per cycle and issues the two oldest
// entries in program order, pairing them when dual_issue_unit allows.
//   clk, rst_n        : clock, synchronous active-low reset
//   fetch_valid/two   : fetch offers one (two=0) or two instructions
//   fetch_slot0/1     : older / younger fetched instruction
//   fetch_ready       : room for two more entries (and not flushing)
//   flush             : discard every queued entry
//   issue_ready       : lanes accept this cycle's issue
//   issue0_valid/slot : oldest entry, lane 0
//   issue1_valid/slot : second-oldest entry, lane 1
//   dual_cnt          : saturating count of two-instruction issue cycles
//   single_cnt        : saturating count of one-instruction issue cycles
// ---------------------------------------------------------------------------
module dual_issue_sequencer
    import issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_valid,
    input  logic             fetch_two,
    input  issue_slot_t      fetch_slot0,
    input  issue_slot_t      fetch_slot1,
    output logic             fetch_ready,
    input  logic             flush,
    input  logic             issue_ready,
    output logic             issue0_valid,
    output issue_slot_t      issue0_slot,
    output logic             issue1_valid,
    output issue_slot_t      issue1_slot,
    output logic [CNT_W-1:0] dual_cnt,
    output logic [CNT_W-1:0] single_cnt
);

    localparam int               PTR_W       = $clog2(DEPTH);
    localparam logic [PTR_W:0]   READY_LIMIT = (PTR_W+1)'(DEPTH - 2);

    issue_slot_t      entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_plus1;
    logic [PTR_W-1:0] wr_ptr_plus1;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   push_n;
    logic [PTR_W:0]   pop_n;
    logic [1:0]       pop;
    logic             push;
    logic             has_one;
    logic             has_two;
    logic             unit_issue0;
    logic             unit_issue1;

    assign rd_ptr_plus1 = rd_ptr + 1'b1;
    assign wr_ptr_plus1 = wr_ptr + 1'b1;
    assign has_one      = (count != '0);
    assign has_two      = (count >= (PTR_W+1)'(2));

    // Readiness depends only on occupancy and flush, never on issue_ready,
    // so fetch sees no combinational path through the execute lanes.
    assign fetch_ready  = (count <= READY_LIMIT) && !flush;
    assign push         = fetch_valid && fetch_ready;
    assign push_n       = !push    ? '0 :
                          fetch_two ? (PTR_W+1)'(2) : (PTR_W+1)'(1);

    assign issue0_slot  = entries[rd_ptr];
    assign issue1_slot  = entries[rd_ptr_plus1];

    dual_issue_unit u_pair (
        .valid0 (has_one),
        .valid1 (has_two),
        .slot0  (issue0_slot),
        .slot1  (issue1_slot),
        .issue0 (unit_issue0),
        .issue1 (unit_issue1)
    );

    assign issue0_valid = unit_issue0 && !flush;
    assign issue1_valid = unit_issue1 && !flush;
    assign pop          = issue_ready ? ({1'b0, issue0_valid} + {1'b0, issue1_valid})
                                      : 2'd0;
    assign pop_n        = {{(PTR_W-1){1'b0}}, pop};

    // Entry storage has no reset: the pointers and count decide what is
    // live, so stale contents are never presented as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= fetch_slot0;
            if (fetch_two) begin
                entries[wr_ptr_plus1] <= fetch_slot1;
            end
        end
    end

    // Queue bookkeeping. Flush empties the queue; push is already blocked
    // by fetch_ready and pop by the gated valids during a flush cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + push_n[PTR_W-1:0];
            rd_ptr <= rd_ptr + pop_n[PTR_W-1:0];
            count  <= count + push_n - pop_n;
        end
    end

    // Issue statistics saturate so long runs never appear to drop back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dual_cnt   <= '0;
            single_cnt <= '0;
        end else begin
            if (pop == 2'd2 && dual_cnt != '1) begin
                dual_cnt <= dual_cnt + 1'b1;
            end
            if (pop == 2'd1 && single_cnt != '1) begin
                single_cnt <= single_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dual_issue_sequencer
// Directed stimulus with a scoreboard: each accepted instruction is queued
// with the lane it should leave on; an independent monitor checks every
// issued instruction against that queue.
// ---------------------------------------------------------------------------
module tb_dual_issue_sequencer;
    import issue_pkg::*;

    typedef struct {
        issue_slot_t slot;
        logic        lane;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic        fetch_two;
    issue_slot_t fetch_slot0;
    issue_slot_t fetch_slot1;
    logic        fetch_ready;
    logic        flush;
    logic        issue_ready;
    logic        issue0_valid;
    issue_slot_t issue0_slot;
    logic        issue1_valid;
    issue_slot_t issue1_slot;
    logic [31:0] dual_cnt;
    logic [31:0] single_cnt;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    dual_issue_sequencer #(.DEPTH(4), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_valid  (fetch_valid),
        .fetch_two    (fetch_two),
        .fetch_slot0  (fetch_slot0),
        .fetch_slot1  (fetch_slot1),
        .fetch_ready  (fetch_ready),
        .flush        (flush),
        .issue_ready  (issue_ready),
        .issue0_valid (issue0_valid),
        .issue0_slot  (issue0_slot),
        .issue1_valid (issue1_valid),
        .issue1_slot  (issue1_slot),
        .dual_cnt     (dual_cnt),
        .single_cnt   (single_cnt)
    );

    // Free-running clock, posedge at 5, 15, 25 ...
    always #5 clk = ~clk;

    function automatic issue_slot_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic ld, input logic st,
                                       input logic br, input logic jp);
        issue_slot_t s;
        s.pc        = pc;
        s.instr     = pc ^ 32'h0000_0013;
        s.rd        = rd;
        s.rs1       = rs1;
        s.rs2       = rs2;
        s.is_load   = ld;
        s.is_store  = st;
        s.is_branch = br;
        s.is_jump   = jp;
        return s;
    endfunction

    task automatic applyStimulus(input logic fv, input logic two, input issue_slot_t s0,
                                 input issue_slot_t s1, input logic fl, input logic ir);
        fetch_valid = fv;
        fetch_two   = two;
        fetch_slot0 = s0;
        fetch_slot1 = s1;
        flush       = fl;
        issue_ready = ir;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expectIssue(input issue_slot_t s, input logic lane);
        exp_t e;
        e.slot = s;
        e.lane = lane;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkLane(input logic lane, input issue_slot_t got);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_issue: lane %0d pc %h with empty scoreboard",
                     lane, got.pc);
        end else begin
            e = exp_q.pop_front();
            if (e.lane !== lane || e.slot !== got) begin
                errors++;
                $display("[TB] FAIL issue_order: got lane %0d pc %h, expected lane %0d pc %h",
                         lane, got.pc, e.lane, e.slot.pc);
            end
        end
    endtask

    // Monitor: samples mid-cycle, consuming scoreboard entries only for
    // instructions that actually leave the queue this cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && issue_ready === 1'b1) begin
                if (issue0_valid === 1'b1) checkLane(1'b0, issue0_slot);
                if (issue1_valid === 1'b1) checkLane(1'b1, issue1_slot);
            end
        end
    end

    // Directed sequence.
    initial begin
        issue_slot_t a, b;
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, mk(32'h900, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0),
                      mk(32'h904, 5'd4, 5'd5, 5'd6, 0, 0, 0, 0), 1'b0, 1'b0);

        // Reset held two cycles while fetch offers work.
        step();
        step();
        checkOutput("rst_issue0_valid", {31'd0, issue0_valid}, 0);
        checkOutput("rst_issue1_valid", {31'd0, issue1_valid}, 0);
        checkOutput("rst_fetch_ready", {31'd0, fetch_ready}, 1);
        checkOutput("rst_dual_cnt", dual_cnt, 0);
        checkOutput("rst_single_cnt", single_cnt, 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        step();
        checkOutput("post_rst_empty", {31'd0, issue0_valid}, 0);

        // Independent pair dual-issues.
        a = mk(32'h100, 5'd3, 5'd1, 5'd2, 0, 0, 0, 0);
        b = mk(32'h104, 5'd6, 5'd4, 5'd5, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, a, b, 1'b0, 1'b1);
        expectIssue(a, 1'b0);
        expectIssue(b, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("pair_issue1_valid", {31'd0, issue1_valid}, 1);
        step();
        checkOutput("pair_drained", {31'd0, issue0_valid}, 0);
        checkOutput("pair_dual_cnt", dual_cnt, 1);

        // RAW pair splits across two cycles, both on lane 0.
        a = mk(32'h200, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);
        b = mk(32'h204, 5'd4, 5'd1, 5'd5, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, a, b, 1'b0, 1'b1);
        expectIssue(a, 1'b0);
        expectIssue(b, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("raw_issue1_blocked", {31'd0, issue1_valid}, 0);
        step();
        step();
        checkOutput("raw_single_cnt", single_cnt, 2);
        checkOutput("raw_dual_cnt", dual_cnt, 1);

        // Fill to DEPTH with the lanes stalled; a third pair must bounce.
        applyStimulus(1'b1, 1'b1, mk(32'h300, 5'd7, 5'd1, 5'd2, 0, 0, 0, 0),
                      mk(32'h304, 5'd8, 5'd1, 5'd2, 0, 0, 0, 0), 1'b0, 1'b0);
        expectIssue(fetch_slot0, 1'b0);
        expectIssue(fetch_slot1, 1'b1);
        step();
        applyStimulus(1'b1, 1'b1, mk(32'h308, 5'd9, 5'd1, 5'd2, 0, 0, 0, 0),
                      mk(32'h30c, 5'd10, 5'd1, 5'd2, 0, 0, 0, 0), 1'b0, 1'b0);
        expectIssue(fetch_slot0, 1'b0);
        expectIssue(fetch_slot1, 1'b1);
        step();
        checkOutput("full_fetch_ready", {31'd0, fetch_ready}, 0);
        checkOutput("stall_valid_held", {31'd0, issue0_valid}, 1);
        applyStimulus(1'b1, 1'b1, mk(32'h310, 5'd11, 5'd1, 5'd2, 0, 0, 0, 0),
                      mk(32'h314, 5'd12, 5'd1, 5'd2, 0, 0, 0, 0), 1'b0, 1'b0);
        step();
        checkOutput("full_still_blocked", {31'd0, fetch_ready}, 0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        step();
        checkOutput("drain_fetch_ready", {31'd0, fetch_ready}, 1);
        step();
        checkOutput("drain_empty", {31'd0, issue0_valid}, 0);
        checkOutput("full_dual_cnt", dual_cnt, 3);

        // Flush with three entries queued and fetch offering a pair.
        applyStimulus(1'b1, 1'b1, mk(32'h400, 5'd1, 5'd0, 5'd0, 0, 0, 0, 0),
                      mk(32'h404, 5'd2, 5'd0, 5'd0, 0, 0, 0, 0), 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, mk(32'h408, 5'd3, 5'd0, 5'd0, 0, 0, 0, 0),
                      '0, 1'b0, 1'b0);
        step();
        exp_q.delete();
        applyStimulus(1'b1, 1'b1, mk(32'h40c, 5'd4, 5'd0, 5'd0, 0, 0, 0, 0),
                      mk(32'h410, 5'd5, 5'd0, 5'd0, 0, 0, 0, 0), 1'b1, 1'b1);
        #1;
        checkOutput("flush_fetch_ready", {31'd0, fetch_ready}, 0);
        checkOutput("flush_issue0_valid", {31'd0, issue0_valid}, 0);
        checkOutput("flush_issue1_valid", {31'd0, issue1_valid}, 0);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        #1;
        checkOutput("after_flush_issue0", {31'd0, issue0_valid}, 0);
        checkOutput("after_flush_issue1", {31'd0, issue1_valid}, 0);
        checkOutput("flush_keeps_dual", dual_cnt, 3);
        checkOutput("flush_keeps_single", single_cnt, 2);

        // Pair-rule corner cases, one pair at a time.
        for (int k = 0; k < 4; k++) begin
            logic lane_b;
            case (k)
                0: begin  // load + store share the memory port
                    a = mk(32'h500, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0);
                    b = mk(32'h504, 5'd0, 5'd4, 5'd5, 0, 1, 0, 0);
                    lane_b = 1'b0;
                end
                1: begin  // branch always issues alone
                    a = mk(32'h510, 5'd0, 5'd2, 5'd3, 0, 0, 1, 0);
                    b = mk(32'h514, 5'd6, 5'd4, 5'd5, 0, 0, 0, 0);
                    lane_b = 1'b0;
                end
                2: begin  // WAW on x7
                    a = mk(32'h520, 5'd7, 5'd2, 5'd3, 0, 0, 0, 0);
                    b = mk(32'h524, 5'd7, 5'd4, 5'd5, 0, 0, 0, 0);
                    lane_b = 1'b0;
                end
                default: begin  // single memory op pairs fine
                    a = mk(32'h530, 5'd8, 5'd2, 5'd3, 1, 0, 0, 0);
                    b = mk(32'h534, 5'd9, 5'd4, 5'd5, 0, 0, 0, 0);
                    lane_b = 1'b1;
                end
            endcase
            applyStimulus(1'b1, 1'b1, a, b, 1'b0, 1'b1);
            expectIssue(a, 1'b0);
            expectIssue(b, lane_b);
            step();
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
            step();
            step();
            step();
        end
        checkOutput("rules_single_cnt", single_cnt, 8);
        checkOutput("rules_dual_cnt", dual_cnt, 4);

        // Ten x0-only pairs streamed back to back across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            a = mk(32'h1000 + 32'(i * 8), 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
            b = mk(32'h1004 + 32'(i * 8), 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
            applyStimulus(1'b1, 1'b1, a, b, 1'b0, 1'b1);
            expectIssue(a, 1'b0);
            expectIssue(b, 1'b1);
            step();
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        step();
        step();
        checkOutput("wrap_dual_cnt", dual_cnt, 14);
        checkOutput("wrap_empty", {31'd0, issue0_valid}, 0);

        // Reset in the middle of a stalled queue.
        applyStimulus(1'b1, 1'b1, mk(32'h600, 5'd1, 5'd0, 5'd0, 0, 0, 0, 0),
                      mk(32'h604, 5'd2, 5'd0, 5'd0, 0, 0, 0, 0), 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        checkOutput("midrst_issue0_valid", {31'd0, issue0_valid}, 0);
        checkOutput("midrst_fetch_ready", {31'd0, fetch_ready}, 1);
        checkOutput("midrst_dual_cnt", dual_cnt, 0);
        checkOutput("midrst_single_cnt", single_cnt, 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        step();
        step();

        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
